// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants and types for the multiplexed seven-segment display driver.
// Segment codes are active-low g..a; anode patterns are active-low one-cold.
package seg7_scan_driver_pkg;

   localparam int unsigned NIBBLE_W  = 4;
   localparam int unsigned SEG_W     = 7;
   localparam int unsigned IDX_W     = 2;
   localparam int unsigned DIGITS_W  = 16;
   localparam int unsigned ANODE_W   = 4;
   localparam int unsigned HEX_W     = 8;

   localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   localparam logic [ANODE_W-1:0] ANODE_OFF = 4'hF;
   localparam logic [HEX_W-1:0]   HEX_OFF   = 8'hFF;

   // Per-frame capture of the display request, held for a whole scan frame.
   typedef struct packed {
      logic [DIGITS_W-1:0] digits;
      logic [ANODE_W-1:0]  dp;
      logic                blank_lz;
   } snap_t;

   // Active-low one-cold anode pattern for a digit index.
   function automatic logic [ANODE_W-1:0] anode_sel(input logic [IDX_W-1:0] idx);
      logic [ANODE_W-1:0] hot;
      hot = ANODE_W'(1) << idx;
      return ~hot;
   endfunction

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// BCD nibble to active-low seven-segment decoder; non-decimal nibbles show a
// dash and the blank flag forces every segment off.
module bcd_to_seg7
   import seg7_scan_driver_pkg::*;
(
   input  logic [NIBBLE_W-1:0] nibble,
   input  logic                blank,
   output logic [SEG_W-1:0]    seg_c
);

   always_comb begin
      seg_c = SEG_DASH;
      if (blank) begin
         seg_c = SEG_BLANK;
      end else begin
         unique case (nibble)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit time-multiplexed seven-segment driver with per-frame input
// snapshot, leading-zero blanking and per-digit decimal points.
module seg7_scan_driver
   import seg7_scan_driver_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 100000,
   parameter int unsigned DIV_WIDTH = 17
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                ENABLE,
   input  logic [DIGITS_W-1:0] DIGITS,
   input  logic [ANODE_W-1:0]  DP_IN,
   input  logic                BLANK_LZ,
   output logic [ANODE_W-1:0]  SEG_SELECT,
   output logic [HEX_W-1:0]    HEX_OUT,
   output logic [IDX_W-1:0]    DIGIT_IDX,
   output logic                FRAME_TICK
);

   localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(3);

   logic [DIV_WIDTH-1:0] div_cnt;
   logic [IDX_W-1:0]     idx;
   snap_t                snap;

   logic                 terminal_c;
   logic [ANODE_W-1:0]   lz_mask_c;
   logic [NIBBLE_W-1:0]  nibble_c;
   logic                 blank_c;
   logic                 dp_c;
   logic [SEG_W-1:0]     seg_c;

   assign terminal_c = (div_cnt == DIV_LAST);

   // A digit is blanked only while every more-significant digit is also zero.
   always_comb begin
      lz_mask_c    = '0;
      lz_mask_c[3] = snap.blank_lz && (snap.digits[15:12] == 4'd0);
      lz_mask_c[2] = lz_mask_c[3]  && (snap.digits[11:8]  == 4'd0);
      lz_mask_c[1] = lz_mask_c[2]  && (snap.digits[7:4]   == 4'd0);
      lz_mask_c[0] = 1'b0;
   end

   always_comb begin
      nibble_c = snap.digits[{idx, 2'b00} +: NIBBLE_W];
      blank_c  = lz_mask_c[idx];
      dp_c     = snap.dp[idx];
   end

   bcd_to_seg7 u_dec (
      .nibble (nibble_c),
      .blank  (blank_c),
      .seg_c  (seg_c)
   );

   // Prescaler, scan index and frame snapshot; all frozen while disabled.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         div_cnt    <= '0;
         idx        <= '0;
         snap       <= '0;
         FRAME_TICK <= 1'b0;
      end else begin
         FRAME_TICK <= 1'b0;
         if (ENABLE) begin
            if (terminal_c) begin
               div_cnt <= '0;
               idx     <= idx + IDX_W'(1);
               if (idx == IDX_LAST) begin
                  snap.digits   <= DIGITS;
                  snap.dp       <= DP_IN;
                  snap.blank_lz <= BLANK_LZ;
                  FRAME_TICK    <= 1'b1;
               end
            end else begin
               div_cnt <= div_cnt + DIV_WIDTH'(1);
            end
         end
      end
   end

   // Registered display outputs, one cycle behind the scan index.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         SEG_SELECT <= ANODE_OFF;
         HEX_OUT    <= HEX_OFF;
         DIGIT_IDX  <= '0;
      end else begin
         DIGIT_IDX <= idx;
         if (ENABLE) begin
            SEG_SELECT <= anode_sel(idx);
            HEX_OUT    <= {~dp_c, seg_c};
         end else begin
            SEG_SELECT <= ANODE_OFF;
            HEX_OUT    <= HEX_OFF;
         end
      end
   end

endmodule
